dev_bridge_ctrl: RTL and testbench
==================================

// Module: dev_bridge_ctrl
// PURPOSE
//  Sequences CPU M-stage accesses to memory-mapped devices in window 0x00007F00-0x00007FFF.
//  Decodes the device index, runs a req/ack handshake with the selected device and stalls
//  the pipeline until the device acks or a timeout fires. Returns read data for the
//  realdmM path.
//  DM-range and other non-device addresses pass untouched; stall and bus_err stay 0 for them.
// PARAMETERS
//  NDEV     4   number of devices; device i owns 16-byte slot 0x7F00+16*i, index = addr[7:4]
//  TIMEOUT  15  max BUSY cycles without ack before error completion (>=1)
// PORTS
//  clk        in   1        system clock, rising edge
//  reset      in   1        asynchronous, active-high reset
//  cpu_addr   in   32       M-stage memory address (addr[1:0] ignored, word access only)
//  cpu_wdata  in   32       M-stage store data
//  cpu_we     in   1        M-stage store
//  cpu_re     in   1        M-stage load
//  cpu_rdata  out  32       device read data, valid in DONE cycle
//  stall      out  1        freeze IF/ID/EX/M, bubble W
//  bus_err    out  1        1-cycle pulse: unmapped device slot or timeout
//  dev_addr   out  32       latched access address
//  dev_wdata  out  32       latched store data
//  dev_we     out  1        latched write flag, meaningful only while dev_req=1
//  dev_req    out  1        request strobe, high for whole BUSY state
//  dev_sel    out  NDEV     one-hot device select, high with dev_req
//  dev_ack    in   NDEV     per-device ack, sampled on clk
//  dev_rdata  in   NDEV*32  flat read buses, device i at [32*i+31:32*i]
// BEHAVIOUR
//  Decode: hit = (cpu_addr[31:8]==24'h00007f) && (cpu_re|cpu_we)
//  - mapped = hit && addr[7:4] < NDEV; unmapped = hit && !mapped
//  FSM: IDLE, BUSY, DONE. Reset (async) -> IDLE; all registered outputs 0; cnt=0; err_q=0.
//  IDLE:
//  - mapped: latch addr/wdata/we/index; cnt<=0; ->BUSY; stall=1 this cycle (comb)
//  - unmapped: bus_err=1, stall=0, no handshake, cpu_rdata=0; stay IDLE
//  - otherwise idle, stall=0
//  BUSY:
//  - dev_req=1, dev_sel=1<<index, stall=1
//  - dev_ack[index]=1: rdata_q<=dev_rdata[index]; err_q<=0; ->DONE
//  - else cnt==TIMEOUT-1: rdata_q<=0; err_q<=1; ->DONE
//  - else cnt<=cnt+1
//  - ack on a non-selected device: ignored
//  - ack and timeout in same cycle: ack wins
//  DONE:
//  - stall=0, dev_req=0, cpu_rdata=rdata_q, bus_err=err_q; ->IDLE unconditionally
//  - cpu inputs not decoded here, so the still-present request never re-triggers
//  Latency: ack at first BUSY edge -> 2 stall cycles, cpu_rdata on 3rd cycle.
//  - worst case TIMEOUT+1 stall cycles
//  Stores to device commit on ack; a timed-out store has no defined device effect.
//  - CPU is not told beyond bus_err
//  cnt width = clog2(TIMEOUT)+1; never wraps, since it is cleared on BUSY entry.
//  Reset mid-BUSY: dev_req/dev_sel drop immediately (async); late ack after reset ignored.
//  dev_addr/dev_wdata/dev_we hold last latched value outside BUSY; rdata_q holds until next DONE.
// TESTING
//  1. lw 0x7F14, dev1 acks at 1st BUSY edge with 0xDEADBEEF -> 2 stall cycles
//     -> DONE cpu_rdata=0xDEADBEEF, bus_err=0, dev_sel=4'b0010
//  2. sw 0x7F08 wdata=0x12345678, dev0 acks after 3 cycles -> dev_we=1, dev_wdata=0x12345678
//     -> stall 4 cycles, then release
//  3. lw 0x7F30, no ack -> exactly TIMEOUT=15 BUSY cycles -> DONE bus_err=1, cpu_rdata=0
//  4. lw 0x7F50 (slot 5 >= NDEV) -> bus_err pulse same cycle, stall=0, dev_req never set
//  5. lw 0x00001000, then 0x00002004 (DM) -> stall=0, dev_req=0, bus_err=0 throughout
//  6. assert reset mid-BUSY -> dev_req/stall 0 immediately; state IDLE; next access runs normally

Source files
------------

// File: rtl/dev_bridge_ctrl.sv
// -----------------------------------------------------------------------------
// dev_bridge_ctrl
//
// Handles CPU M-stage loads and stores to memory-mapped devices in the window
// 0x00007F00-0x00007FFF. Device i owns the 16-byte slot at 0x7F00 + 16*i, so
// the slot number is addr[7:4]. On an access to a mapped slot the controller
// latches the access, runs a req/ack handshake with the selected device and
// stalls the pipeline until the device acks or TIMEOUT BUSY cycles pass
// without an ack. Accesses to empty slots inside the window get a one-cycle
// bus_err and no handshake. All other addresses are ignored.
//
// Parameters
//   NDEV     number of devices (1..16)
//   TIMEOUT  max BUSY cycles without ack before error completion (>= 1)
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   cpu_addr   in   M-stage address (word access, addr[1:0] don't care)
//   cpu_wdata  in   M-stage store data
//   cpu_we     in   M-stage store
//   cpu_re     in   M-stage load
//   cpu_rdata  out  device read data, valid in the DONE cycle, else 0
//   stall      out  freeze IF/ID/EX/M, bubble W
//   bus_err    out  1-cycle pulse: unmapped slot or device timeout
//   dev_addr   out  latched access address
//   dev_wdata  out  latched store data
//   dev_we     out  latched write flag (meaningful while dev_req = 1)
//   dev_req    out  request strobe, high for the whole BUSY state
//   dev_sel    out  one-hot device select, high together with dev_req
//   dev_ack    in   per-device ack
//   dev_rdata  in   flat read buses, device i at [32*i+31:32*i]
// -----------------------------------------------------------------------------
module dev_bridge_ctrl #(
    parameter int NDEV    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          cpu_addr,
    input  logic [31:0]          cpu_wdata,
    input  logic                 cpu_we,
    input  logic                 cpu_re,
    output logic [31:0]          cpu_rdata,
    output logic                 stall,
    output logic                 bus_err,
    output logic [31:0]          dev_addr,
    output logic [31:0]          dev_wdata,
    output logic                 dev_we,
    output logic                 dev_req,
    output logic [NDEV-1:0]      dev_sel,
    input  logic [NDEV-1:0]      dev_ack,
    input  logic [NDEV*32-1:0]   dev_rdata
);

    localparam int IDXW = (NDEV > 1) ? $clog2(NDEV) : 1;
    // One extra bit of headroom; the counter is cleared on every BUSY entry
    // and stops at TIMEOUT-1, so it never wraps.
    localparam int CNTW = $clog2(TIMEOUT) + 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_reg;
    logic [IDXW-1:0]   idx_reg;
    logic [CNTW-1:0]   cnt_reg;
    logic [31:0]       rdata_reg;
    logic              err_reg;
    logic [31:0]       addr_reg;
    logic [31:0]       wdata_reg;
    logic              we_reg;

    // ------------------------------------------------------------------
    // Address decode (only consulted in IDLE)
    // ------------------------------------------------------------------
    logic       hit;
    logic       mapped;
    logic       unmapped;
    logic [3:0] slot;

    assign slot     = cpu_addr[7:4];
    assign hit      = (cpu_addr[31:8] == 24'h00007F) && (cpu_re || cpu_we);
    assign mapped   = hit && (int'(slot) < NDEV);
    assign unmapped = hit && !mapped;

    // ------------------------------------------------------------------
    // Per-device select and read-bus unpacking
    // ------------------------------------------------------------------
    logic        busy;
    logic [31:0] rdata_word [NDEV];
    logic        ack_sel;

    assign busy = (state_reg == ST_BUSY);

    genvar gi;
    generate
        for (gi = 0; gi < NDEV; gi++) begin : g_dev
            assign rdata_word[gi] = dev_rdata[32*gi +: 32];
            assign dev_sel[gi]    = busy && (idx_reg == IDXW'(gi));
        end
    endgenerate

    // Only the selected device's ack counts; acks from others are masked.
    assign ack_sel = |(dev_ack & dev_sel);

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
            cnt_reg   <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            we_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (mapped) begin
                        addr_reg  <= cpu_addr;
                        wdata_reg <= cpu_wdata;
                        we_reg    <= cpu_we;
                        idx_reg   <= cpu_addr[4 +: IDXW];
                        cnt_reg   <= '0;
                        state_reg <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // Ack takes priority over a timeout landing in the same cycle.
                    if (ack_sel) begin
                        rdata_reg <= rdata_word[idx_reg];
                        err_reg   <= 1'b0;
                        state_reg <= ST_DONE;
                    end else if (cnt_reg == CNT_LAST) begin
                        rdata_reg <= '0;
                        err_reg   <= 1'b1;
                        state_reg <= ST_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_DONE: begin
                    // The CPU request is still present this cycle; returning to
                    // IDLE without decoding keeps it from re-triggering.
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The IDLE-cycle stall must be combinational so the pipeline freezes in
    // the same cycle the access is first seen. Both CPU-facing strobes are
    // held low while reset is asserted so a pending access cannot stall or
    // flag an error during reset.
    assign stall   = !reset && (((state_reg == ST_IDLE) && mapped) || busy);
    assign bus_err = !reset && (((state_reg == ST_IDLE) && unmapped) ||
                                ((state_reg == ST_DONE) && err_reg));
    assign cpu_rdata = (state_reg == ST_DONE) ? rdata_reg : 32'h0;

    assign dev_req   = busy;
    assign dev_addr  = addr_reg;
    assign dev_wdata = wdata_reg;
    assign dev_we    = we_reg;

endmodule

// File: tb/tb_dev_bridge_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dev_bridge_ctrl
//
// Cycle-by-cycle vector table for single-transaction sequences (ack after one
// and three cycles, unmapped slot, non-device addresses), plus hand-written
// sequences for timeout, ack-vs-timeout on the last cycle and reset mid-BUSY.
// Inputs are driven 1 time unit after the rising edge and outputs are
// checked on the falling edge.
// -----------------------------------------------------------------------------
module tb_dev_bridge_ctrl;

    localparam int NDEV    = 4;
    localparam int TIMEOUT = 15;

    logic              clk;
    logic              reset;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_we;
    logic              cpu_re;
    logic [31:0]       cpu_rdata;
    logic              stall;
    logic              bus_err;
    logic [31:0]       dev_addr;
    logic [31:0]       dev_wdata;
    logic              dev_we;
    logic              dev_req;
    logic [NDEV-1:0]   dev_sel;
    logic [NDEV-1:0]   dev_ack;
    logic [NDEV*32-1:0] dev_rdata;

    dev_bridge_ctrl #(.NDEV(NDEV), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_re    (cpu_re),
        .cpu_rdata (cpu_rdata),
        .stall     (stall),
        .bus_err   (bus_err),
        .dev_addr  (dev_addr),
        .dev_wdata (dev_wdata),
        .dev_we    (dev_we),
        .dev_req   (dev_req),
        .dev_sel   (dev_sel),
        .dev_ack   (dev_ack),
        .dev_rdata (dev_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Device dsel drives data; every other device drives a recognisable junk
    // word so a wrong read mux is visible.
    task automatic drive_rdata(input int dsel, input logic [31:0] data);
        for (int d = 0; d < NDEV; d++)
            dev_rdata[32*d +: 32] = (d == dsel) ? data : (32'hBAD0_0000 | 32'(d));
    endtask

    task automatic drive_cpu(input logic [31:0] a, input logic [31:0] wd,
                             input logic we, input logic re);
        cpu_addr  = a;
        cpu_wdata = wd;
        cpu_we    = we;
        cpu_re    = re;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        re;
        logic [3:0]  ack;
        int          dsel;
        logic [31:0] data;
        logic        e_stall;
        logic        e_err;
        logic        e_req;
        logic [3:0]  e_sel;
        logic [31:0] e_rdata;
        logic        e_we;
    } vec_t;

    function automatic vec_t mk(logic [31:0] addr, logic [31:0] wdata, logic we, logic re,
                                logic [3:0] ack, int dsel, logic [31:0] data,
                                logic e_stall, logic e_err, logic e_req, logic [3:0] e_sel,
                                logic [31:0] e_rdata, logic e_we);
        vec_t v;
        v.addr = addr; v.wdata = wdata; v.we = we; v.re = re;
        v.ack = ack; v.dsel = dsel; v.data = data;
        v.e_stall = e_stall; v.e_err = e_err; v.e_req = e_req; v.e_sel = e_sel;
        v.e_rdata = e_rdata; v.e_we = e_we;
        return v;
    endfunction

    vec_t vecs [16];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cycles;
        bit done_seen;

        //            addr          wdata         we    re    ack      ds data          st    err   req   sel      rdata         we
        // lw 0x7F14, dev1 acks at the first BUSY edge
        vecs[0]  = mk(32'h00007F14, 32'h0,        1'b0, 1'b1, 4'b0000, 1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0,        1'b0);
        vecs[1]  = mk(32'h00007F14, 32'h0,        1'b0, 1'b1, 4'b0010, 1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 4'b0010, 32'h0,        1'b0);
        vecs[2]  = mk(32'h00007F14, 32'h0,        1'b0, 1'b1, 4'b0000, 1, 32'h0,        1'b0, 1'b0, 1'b0, 4'b0000, 32'hDEADBEEF, 1'b0);
        vecs[3]  = mk(32'h0,        32'h0,        1'b0, 1'b0, 4'b0000, 0, 32'h0,        1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        1'b0);
        // sw 0x7F08, dev0 acks at the third BUSY edge; dev2 acks spuriously first
        vecs[4]  = mk(32'h00007F08, 32'h12345678, 1'b1, 1'b0, 4'b0000, 0, 32'h0,        1'b1, 1'b0, 1'b0, 4'b0000, 32'h0,        1'b0);
        vecs[5]  = mk(32'h00007F08, 32'h12345678, 1'b1, 1'b0, 4'b0000, 0, 32'h0,        1'b1, 1'b0, 1'b1, 4'b0001, 32'h0,        1'b1);
        vecs[6]  = mk(32'h00007F08, 32'h12345678, 1'b1, 1'b0, 4'b0100, 0, 32'h11111111, 1'b1, 1'b0, 1'b1, 4'b0001, 32'h0,        1'b1);
        vecs[7]  = mk(32'h00007F08, 32'h12345678, 1'b1, 1'b0, 4'b0001, 0, 32'hCAFE0000, 1'b1, 1'b0, 1'b1, 4'b0001, 32'h0,        1'b1);
        vecs[8]  = mk(32'h00007F08, 32'h12345678, 1'b1, 1'b0, 4'b0000, 0, 32'h0,        1'b0, 1'b0, 1'b0, 4'b0000, 32'hCAFE0000, 1'b0);
        vecs[9]  = mk(32'h0,        32'h0,        1'b0, 1'b0, 4'b0000, 0, 32'h0,        1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        1'b0);
        // lw 0x7F50: slot 5 is unmapped
        vecs[10] = mk(32'h00007F50, 32'h0,        1'b0, 1'b1, 4'b0000, 0, 32'h0,        1'b0, 1'b1, 1'b0, 4'b0000, 32'h0,        1'b0);
        vecs[11] = mk(32'h0,        32'h0,        1'b0, 1'b0, 4'b0000, 0, 32'h0,        1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        1'b0);
        // non-device addresses and a device address with no access
        vecs[12] = mk(32'h00001000, 32'h0,        1'b0, 1'b1, 4'b0000, 0, 32'h0,        1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        1'b0);
        vecs[13] = mk(32'h00002004, 32'hAAAA5555, 1'b1, 1'b0, 4'b0000, 0, 32'h0,        1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        1'b0);
        vecs[14] = mk(32'h00017F00, 32'h0,        1'b0, 1'b1, 4'b0000, 0, 32'h0,        1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        1'b0);
        vecs[15] = mk(32'h00007F10, 32'h0,        1'b0, 1'b0, 4'b0000, 0, 32'h0,        1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        1'b0);

        // ---------------- reset state ----------------
        reset = 1'b1;
        drive_cpu(32'h0, 32'h0, 1'b0, 1'b0);
        dev_ack = '0;
        drive_rdata(0, 32'h0);
        #3;
        check("rst.stall",   32'(stall),   32'h0);
        check("rst.bus_err", 32'(bus_err), 32'h0);
        check("rst.dev_req", 32'(dev_req), 32'h0);
        check("rst.dev_sel", 32'(dev_sel), 32'h0);
        check("rst.rdata",   cpu_rdata,    32'h0);
        check("rst.dev_addr", dev_addr,    32'h0);
        check("rst.dev_we",  32'(dev_we),  32'h0);
        tick();
        tick();
        reset = 1'b0;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 16; i++) begin
            drive_cpu(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].re);
            dev_ack = vecs[i].ack;
            drive_rdata(vecs[i].dsel, vecs[i].data);
            @(negedge clk);
            $display("vec %0d addr=%h we=%0b re=%0b ack=%b -> stall=%0b err=%0b req=%0b sel=%b rdata=%h",
                     i, vecs[i].addr, vecs[i].we, vecs[i].re, vecs[i].ack,
                     stall, bus_err, dev_req, dev_sel, cpu_rdata);
            check($sformatf("v%0d.stall", i),   32'(stall),   32'(vecs[i].e_stall));
            check($sformatf("v%0d.bus_err", i), 32'(bus_err), 32'(vecs[i].e_err));
            check($sformatf("v%0d.dev_req", i), 32'(dev_req), 32'(vecs[i].e_req));
            check($sformatf("v%0d.dev_sel", i), 32'(dev_sel), 32'(vecs[i].e_sel));
            check($sformatf("v%0d.rdata", i),   cpu_rdata,    vecs[i].e_rdata);
            if (vecs[i].e_req) begin
                check($sformatf("v%0d.dev_we", i),    32'(dev_we), 32'(vecs[i].e_we));
                check($sformatf("v%0d.dev_addr", i),  dev_addr,    vecs[i].addr);
                check($sformatf("v%0d.dev_wdata", i), dev_wdata,   vecs[i].wdata);
            end
            tick();
        end

        // ---------------- timeout: lw 0x7F30, dev3 never acks ----------------
        drive_cpu(32'h00007F30, 32'h0, 1'b0, 1'b1);
        dev_ack = 4'b0001;                 // wrong device, must be ignored
        drive_rdata(3, 32'h77777777);
        @(negedge clk);
        check("to.idle_stall", 32'(stall), 32'h1);
        tick();
        busy_cycles = 0;
        done_seen   = 1'b0;
        for (int k = 0; k < 40 && !done_seen; k++) begin
            @(negedge clk);
            if (dev_req) begin
                busy_cycles++;
                check($sformatf("to.busy%0d.stall", k), 32'(stall), 32'h1);
                tick();
            end else begin
                done_seen = 1'b1;
            end
        end
        check("to.done_seen",   32'(done_seen), 32'h1);
        check("to.busy_cycles", 32'(busy_cycles), 32'(TIMEOUT));
        check("to.bus_err",     32'(bus_err),   32'h1);
        check("to.stall",       32'(stall),     32'h0);
        check("to.rdata",       cpu_rdata,      32'h0);
        $display("timeout: busy_cycles=%0d bus_err=%0b rdata=%h", busy_cycles, bus_err, cpu_rdata);
        tick();
        drive_cpu(32'h0, 32'h0, 1'b0, 1'b0);
        dev_ack = '0;
        @(negedge clk);
        check("to.after_err", 32'(bus_err), 32'h0);
        tick();

        // ---------------- ack on the last BUSY cycle beats timeout ----------------
        drive_cpu(32'h00007F34, 32'h0, 1'b0, 1'b1);
        drive_rdata(3, 32'h55AA33CC);
        tick();                            // now in BUSY, cnt = 0
        for (int k = 0; k < TIMEOUT - 1; k++) tick();
        dev_ack = 4'b1000;                 // during the cnt == TIMEOUT-1 cycle
        @(negedge clk);
        check("race.dev_req", 32'(dev_req), 32'h1);
        tick();
        dev_ack = '0;
        @(negedge clk);
        check("race.bus_err", 32'(bus_err), 32'h0);
        check("race.rdata",   cpu_rdata,    32'h55AA33CC);
        $display("race: bus_err=%0b rdata=%h", bus_err, cpu_rdata);
        tick();
        drive_cpu(32'h0, 32'h0, 1'b0, 1'b0);
        tick();

        // ---------------- reset mid-BUSY ----------------
        drive_cpu(32'h00007F24, 32'h0, 1'b0, 1'b1);
        drive_rdata(2, 32'hFEEDF00D);
        tick();                            // BUSY
        #2;
        check("rstb.req_before", 32'(dev_req), 32'h1);
        reset = 1'b1;
        #1;
        check("rstb.dev_req", 32'(dev_req), 32'h0);
        check("rstb.dev_sel", 32'(dev_sel), 32'h0);
        check("rstb.stall",   32'(stall),   32'h0);
        $display("reset mid-busy: dev_req=%0b stall=%0b", dev_req, stall);
        tick();
        drive_cpu(32'h0, 32'h0, 1'b0, 1'b0);
        dev_ack = 4'b0100;                 // late ack, must be ignored
        reset = 1'b0;
        @(negedge clk);
        check("rstb.late_req",   32'(dev_req), 32'h0);
        check("rstb.late_stall", 32'(stall),   32'h0);
        tick();
        @(negedge clk);
        check("rstb.late_rdata", cpu_rdata,    32'h0);
        tick();
        dev_ack = '0;
        // next access runs normally
        drive_cpu(32'h00007F24, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        check("rstb.next_stall", 32'(stall), 32'h1);
        tick();
        dev_ack = 4'b0100;
        @(negedge clk);
        check("rstb.next_sel", 32'(dev_sel), 32'h4);
        tick();
        dev_ack = '0;
        @(negedge clk);
        check("rstb.next_rdata", cpu_rdata, 32'hFEEDF00D);
        check("rstb.next_err",   32'(bus_err), 32'h0);
        $display("after reset: rdata=%h bus_err=%0b", cpu_rdata, bus_err);
        tick();
        drive_cpu(32'h0, 32'h0, 1'b0, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
